// File: rtl/des_sbox_pipe.sv
// Pipelined bank of the eight DES S-boxes (S1..S8) with valid/ready handshakes on both sides.
// Define DES_SBOX_PERM_EN to apply the DES P-permutation to the substituted word.
module des_sbox_pipe #(
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       occupancy
);
    localparam int unsigned LAST = PIPE_DEPTH - 1;
    localparam int unsigned DW   = 32;

    // Four rows per box, S1 first; column 0 sits in the most significant nibble.
    localparam logic [63:0] SBOX_ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox(input int box, input logic [5:0] b);
        logic [63:0] row;
        int unsigned sh;
        row = SBOX_ROWS[box * 4 + int'({b[5], b[0]})];
        sh  = 32'd60 - 32'd4 * 32'(b[4:1]);
        return 4'(row >> sh);
    endfunction

    logic [DW-1:0]         s_word;
    logic [DW-1:0]         stage_in;
    logic [PIPE_DEPTH-1:0] vld;
    logic [PIPE_DEPTH-1:0] adv;
    logic [DW-1:0]         dat [PIPE_DEPTH];
    logic [TAG_W-1:0]      tag [PIPE_DEPTH];
    logic                  accept;
    logic                  deliver;

    // Combinational lookup feeding the stage-1 register.
    always_comb begin
        s_word = '0;
        for (int b = 0; b < 8; b++) begin
            s_word[31 - 4 * b -: 4] = sbox(b, in_data[47 - 6 * b -: 6]);
        end
    end

`ifdef DES_SBOX_PERM_EN
    localparam int unsigned PERM [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };
    logic [DW-1:0] p_word;

    for (genvar i = 0; i < 32; i++) begin : g_perm
        assign p_word[31 - i] = s_word[32 - PERM[i]];
    end

    assign stage_in = p_word;
`else
    assign stage_in = s_word;
`endif

    // A stage moves when any stage from it to the output has a hole, or the sink is taking data.
    always_comb begin
        adv = '0;
        for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            adv[k] = out_ready;
            for (int j = k; j < int'(PIPE_DEPTH); j++) begin
                if (!vld[j]) adv[k] = 1'b1;
            end
        end
    end

    assign in_ready = adv[0];
    assign accept   = in_valid && adv[0];
    assign deliver  = vld[LAST] && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            occupancy <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                dat[k] <= '0;
                tag[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= stage_in;
                    tag[0] <= in_tag;
                end
            end
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        dat[k] <= dat[k-1];
                        tag[k] <= tag[k-1];
                    end
                end
            end
            case ({accept, deliver})
                2'b10:   occupancy <= occupancy + 3'd1;
                2'b01:   occupancy <= occupancy - 3'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign out_valid = vld[LAST];
    assign out_data  = dat[LAST];
    assign out_tag   = tag[LAST];

endmodule

// File: tb/tb_des_sbox_pipe.sv
// Self-checking bench for des_sbox_pipe: a depth-2 and a depth-3 instance, table vectors,
// a reference S-box model feeding a scoreboard, and hand-written backpressure/reset sequences.
module tb_des_sbox_pipe;

    localparam int SB [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},  '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},  '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},  '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},  '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},  '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},  '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},  '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},  '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},  '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},  '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},  '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},  '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},  '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},  '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},  '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},  '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [47:0] din;
        logic [3:0]  tag;
        logic [31:0] raw;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [47:0] a_in_data;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [31:0] a_out_data;
    logic [2:0]  a_occ;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [47:0] b_in_data;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [31:0] b_out_data;
    logic [2:0]  b_occ;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic acc_a, dlv_a, acc_b, dlv_b;
    int   ndlv_a, stalls_a, nacc_b;
    int   bp_t;
    vec_t vecs [6];

    des_sbox_pipe #(.PIPE_DEPTH(2), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag),
        .occupancy(a_occ)
    );

    des_sbox_pipe #(.PIPE_DEPTH(3), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_raw(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  g;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            g = d[47 - 6 * b -: 6];
            r[31 - 4 * b -: 4] = 4'(SB[b][{g[5], g[0]}][g[4:1]]);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_of(input logic [31:0] raw);
`ifdef DES_SBOX_PERM_EN
        int p [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31 - i] = raw[32 - p[i]];
        return o;
`else
        return raw;
`endif
    endfunction

    function automatic logic [47:0] bp_word(input int t);
        return 48'h0F1E2D3C4B5A ^ {8{6'(t * 5)}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: handshakes are judged at the falling edge, inputs change 1 unit after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc_a = 1'b0; dlv_a = 1'b0; acc_b = 1'b0; dlv_b = 1'b0;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                dlv_a = 1'b1;
                ndlv_a++;
                if (qa.size() == 0) check("a_unexpected_out", 64'(a_out_valid), 64'd0);
                else begin
                    e = qa.pop_front();
                    check("a_sb_data", 64'(a_out_data), 64'(e.data));
                    check("a_sb_tag", 64'(a_out_tag), 64'(e.tag));
                end
            end
            if (a_in_valid && !a_in_ready) stalls_a++;
            if (a_in_valid && a_in_ready) begin
                acc_a = 1'b1;
                qa.push_back('{data: exp_of(ref_raw(a_in_data)), tag: a_in_tag});
            end
            if (b_out_valid && b_out_ready) begin
                dlv_b = 1'b1;
                if (qb.size() == 0) check("b_unexpected_out", 64'(b_out_valid), 64'd0);
                else begin
                    e = qb.pop_front();
                    check("b_sb_data", 64'(b_out_data), 64'(e.data));
                    check("b_sb_tag", 64'(b_out_tag), 64'(e.tag));
                end
            end
            if (b_in_valid && b_in_ready) begin
                acc_b = 1'b1;
                nacc_b++;
                qb.push_back('{data: exp_of(ref_raw(b_in_data)), tag: b_in_tag});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bp_advance();
        if (acc_b) begin
            if (bp_t < 5) begin
                bp_t++;
                b_in_data = bp_word(bp_t);
                b_in_tag  = 4'(bp_t);
            end else begin
                b_in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int viol, unstable, first, last, cnt, acc, dlv, pulses;
        logic        have_cap;
        logic [31:0] cap_d;
        logic [3:0]  cap_t;

        vecs[0] = '{48'h000000000000, 4'h3, 32'hEFA72C4D};
        vecs[1] = '{48'hFFFFFFFFFFFF, 4'h5, 32'hD9CE3DCB};
        vecs[2] = '{48'h000040000000, 4'h6, 32'hEFD72C4D};
        vecs[3] = '{48'h000FC0000000, 4'h7, 32'hEFC72C4D};
        vecs[4] = '{48'h041041041041, 4'h8, 32'h03DDEAD1};
        vecs[5] = '{48'h820820820820, 4'h9, 32'h40DA4917};

        ndlv_a = 0; stalls_a = 0; nacc_b = 0; bp_t = 0;
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 48'hFFFFFFFFFFFF; a_in_tag = 4'hF; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 48'hFFFFFFFFFFFF; b_in_tag = 4'hF; b_out_ready = 1'b1;

        // Reset held two cycles with valid input present.
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_out_valid", 64'(a_out_valid), 64'd0);
            check("rst_out_data", 64'(a_out_data), 64'd0);
            check("rst_out_tag", 64'(a_out_tag), 64'd0);
            check("rst_occ", 64'(a_occ), 64'd0);
            check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        check("rel_in_ready", 64'(a_in_ready), 64'd1);
        step();
        check("idle_occ", 64'(a_occ), 64'd0);
        check("idle_out_valid", 64'(a_out_valid), 64'd0);
        check("idle_in_ready", 64'(a_in_ready), 64'd1);

        // Table vectors, one at a time, checking latency and values directly.
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = vecs[i].din;
            a_in_tag   = vecs[i].tag;
            step();
            a_in_valid = 1'b0;
            check($sformatf("vec%0d_early_valid", i), 64'(a_out_valid), 64'd0);
            check($sformatf("vec%0d_occ", i), 64'(a_occ), 64'd1);
            step();
            check($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(a_out_data), 64'(exp_of(vecs[i].raw)));
            check($sformatf("vec%0d_tag", i), 64'(a_out_tag), 64'(vecs[i].tag));
`ifdef DES_SBOX_PERM_EN
            if (i == 0) check("perm_zero", 64'(a_out_data), 64'h00000000D8D8DBBC);
`endif
            step();
            check($sformatf("vec%0d_drained", i), 64'(a_out_valid), 64'd0);
        end

        // Back-to-back sweep: every index into every box, one word per cycle.
        ndlv_a = 0;
        stalls_a = 0;
        for (int i = 0; i < 64; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = {8{6'(i)}};
            a_in_tag   = 4'(i);
            step();
        end
        a_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("sweep_delivered", 64'(ndlv_a), 64'd64);
        check("sweep_stalls", 64'(stalls_a), 64'd0);
        check("sweep_occ", 64'(a_occ), 64'd0);

        // Backpressure on the depth-3 pipe: five words offered, sink stalled.
        b_out_ready = 1'b0;
        nacc_b = 0;
        bp_t = 1;
        b_in_valid = 1'b1;
        b_in_data = bp_word(1);
        b_in_tag = 4'd1;
        viol = 0; unstable = 0; have_cap = 1'b0; cap_d = '0; cap_t = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            bp_advance();
            if ((b_occ == 3'd3) == b_in_ready) viol++;
            if (b_out_valid) begin
                if (!have_cap) begin
                    cap_d = b_out_data;
                    cap_t = b_out_tag;
                    have_cap = 1'b1;
                end else if (b_out_data !== cap_d || b_out_tag !== cap_t) begin
                    unstable++;
                end
            end
        end
        check("bp_accepted", 64'(nacc_b), 64'd3);
        check("bp_occ", 64'(b_occ), 64'd3);
        check("bp_in_ready", 64'(b_in_ready), 64'd0);
        check("bp_ready_vs_occ", 64'(viol), 64'd0);
        check("bp_stable", 64'(unstable), 64'd0);
        check("bp_head_tag", 64'(b_out_tag), 64'd1);
        check("bp_head_data", 64'(b_out_data), 64'(exp_of(ref_raw(bp_word(1)))));

        b_out_ready = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (dlv_b) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            bp_advance();
        end
        check("bp_delivered", 64'(cnt), 64'd5);
        check("bp_consecutive", 64'(last - first), 64'd4);
        check("bp_total_acc", 64'(nacc_b), 64'd5);

        // Full pipe with simultaneous accept and deliver.
        b_out_ready = 1'b0;
        bp_t = 10;
        b_in_valid = 1'b1;
        b_in_data = bp_word(bp_t);
        b_in_tag = 4'(bp_t);
        for (int c = 0; c < 8 && b_occ != 3'd3; c++) begin
            step();
            if (acc_b) begin
                bp_t++;
                b_in_data = bp_word(bp_t);
                b_in_tag = 4'(bp_t);
            end
        end
        check("full_fill_occ", 64'(b_occ), 64'd3);
        b_out_ready = 1'b1;
        acc = 0; dlv = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            acc += int'(acc_b);
            dlv += int'(dlv_b);
            check($sformatf("full_occ%0d", c), 64'(b_occ), 64'd3);
            bp_t++;
            b_in_data = bp_word(bp_t);
            b_in_tag = 4'(bp_t);
        end
        check("full_accepts", 64'(acc), 64'd4);
        check("full_delivers", 64'(dlv), 64'd4);
        b_in_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check("full_drain_occ", 64'(b_occ), 64'd0);
        check("full_drain_valid", 64'(b_out_valid), 64'd0);
        check("full_drain_queue", 64'(qb.size()), 64'd0);

        // Reset with two words in flight: nothing may emerge afterwards.
        b_in_valid = 1'b1;
        b_in_data = bp_word(20);
        b_in_tag = 4'hA;
        step();
        b_in_data = bp_word(21);
        b_in_tag = 4'hB;
        step();
        b_in_valid = 1'b0;
        check("inflight_occ", 64'(b_occ), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_occ", 64'(b_occ), 64'd0);
        check("midrst_valid", 64'(b_out_valid), 64'd0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (b_out_valid) pulses++;
        end
        check("midrst_no_output", 64'(pulses), 64'd0);
        check("midrst_in_ready", 64'(b_in_ready), 64'd1);
        check("final_queue_a", 64'(qa.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
